hpdcache_rr_arbiter: RTL

// - Round-robin arbiter plus datapath that shares one downstream request channel between NREQ requesters.
// - Produces a one-hot grant and drives it as the select of an internal one-hot hpdcache_mux instance.
// - The grant is locked while a granted request is stalled, so the output stays stable until the handshake completes.
// - Sits in front of shared cache resources such as the miss handler, refill or write-buffer ports.

---
 rtl/hpdcache_rr_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/hpdcache_rr_arbiter.sv
// Purpose : round-robin arbiter with a one-hot payload mux, sharing one downstream channel among NREQ requesters.
// Latency : 0 cycles (combinational in->out); 1 cycle when HPDCACHE_RR_ARBITER_OUT_REG_EN is defined.
// Backpr. : the grant locks while the granted request is stalled; only the granted requester ever sees ready.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   req_valid_i    per-requester valid            req_ready_o   per-requester ready
//   req_data_i     per-requester payload [NREQ-1:0][DATA_WIDTH-1:0]
//   out_valid_o    downstream valid               out_ready_i   downstream ready
//   out_data_o     selected payload               out_gnt_o     one-hot requester on the output (0 when idle)
//
// Optional macro HPDCACHE_RR_ARBITER_OUT_REG_EN adds a 1-entry output register slice.

module hpdcache_mux #(
    parameter int unsigned NINPUT     = 2,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [NINPUT-1:0]                 i_sel,
    input  logic [NINPUT-1:0][DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0]             o_data
);
    // AND-OR mux: a zero select yields zero data.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < NINPUT; i++) begin
            o_data = o_data | (i_data[i] & {DATA_WIDTH{i_sel[i]}});
        end
    end
endmodule

module hpdcache_rr_arbiter #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NREQ-1:0]                req_valid_i,
    output logic [NREQ-1:0]                req_ready_o,
    input  logic [NREQ-1:0][DATA_WIDTH-1:0] req_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    output logic [NREQ-1:0]                out_gnt_o
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                  r_state;
    logic [PW-1:0]           r_ptr;
    logic [NREQ-1:0]         r_gnt;

    logic [NREQ-1:0]         w_mask;
    logic [NREQ-1:0]         w_hi;
    logic [NREQ-1:0]         w_hi_first;
    logic [NREQ-1:0]         w_all_first;
    logic [NREQ-1:0]         w_rr_gnt;
    logic [NREQ-1:0]         w_gnt;
    logic [PW-1:0]           w_gnt_idx;
    logic [PW-1:0]           w_ptr_nxt;
    logic                    w_in_vld;
    logic                    w_in_rdy;
    logic                    w_in_hs;
    logic [DATA_WIDTH-1:0]   w_mux_dat;

    // Requesters at or above the pointer get first pick; if none of them is
    // valid, the search wraps to the lowest valid index overall.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_mask[i] = (PW'(i) >= r_ptr);
        end
    end

    assign w_hi        = req_valid_i & w_mask;
    // x & -x isolates the lowest set bit.
    assign w_hi_first  = w_hi & (~w_hi + NREQ'(1));
    assign w_all_first = req_valid_i & (~req_valid_i + NREQ'(1));
    assign w_rr_gnt    = (|w_hi) ? w_hi_first : w_all_first;

    // Reset forces the grant to zero so every output is quiet while rst_i is high.
    assign w_gnt    = rst_i ? '0 : ((r_state == LOCKED) ? r_gnt : w_rr_gnt);
    assign w_in_vld = |(w_gnt & req_valid_i);
    assign w_in_hs  = w_in_vld & w_in_rdy;

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) w_gnt_idx = PW'(i);
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : (w_gnt_idx + PW'(1));

    hpdcache_mux #(
        .NINPUT     (NREQ),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .i_sel  (w_gnt),
        .i_data (req_data_i),
        .o_data (w_mux_dat)
    );

    // Lock/pointer FSM, driven by the input-side handshake. With a single
    // requester there is nothing to arbitrate, so lock and pointer stay 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if ((NREQ > 1) && w_in_vld && !w_in_rdy) begin
                        r_state <= LOCKED;
                        r_gnt   <= w_gnt;
                    end
                end
                LOCKED: begin
                    if (w_in_hs) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if ((NREQ > 1) && w_in_hs) r_ptr <= w_ptr_nxt;
        end
    end

`ifdef HPDCACHE_RR_ARBITER_OUT_REG_EN
    logic                  r_out_vld;
    logic [DATA_WIDTH-1:0] r_out_dat;
    logic [NREQ-1:0]       r_out_gnt;

    // The slot accepts a new beat when empty or when it drains this cycle.
    assign w_in_rdy = ~r_out_vld | out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_out_gnt <= '0;
        end else if (w_in_hs) begin
            r_out_vld <= 1'b1;
            r_out_dat <= w_mux_dat;
            r_out_gnt <= w_gnt;
        end else if (out_ready_i) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_out_gnt <= '0;
        end
    end

    assign out_valid_o = r_out_vld;
    assign out_data_o  = r_out_dat;
    assign out_gnt_o   = r_out_gnt;
`else
    assign w_in_rdy    = out_ready_i;
    assign out_valid_o = w_in_vld;
    assign out_data_o  = w_mux_dat;
    assign out_gnt_o   = w_gnt;
`endif

    assign req_ready_o = w_gnt & {NREQ{w_in_rdy}};

    // A locked requester must keep its valid asserted until it is accepted.
    a_locked_valid_held: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (r_state == LOCKED) |-> |(r_gnt & req_valid_i)
    );

endmodule
